// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI master: FSM states, mode encodings,
// message width and the key-width helper.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        READ   = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic MODE_ENCR = 1'b0;
    localparam logic MODE_DECR = 1'b1;
    localparam int   MSG_BITS  = 128;

    function automatic int key_bits(input int nk);
        return nk * 32;
    endfunction

endpackage

// File: rtl/aes_spi_master_spi_shift_reg.sv
// Parallel-load, LSB-first right shifter with a registered serial output.
// The serial output drops to 0 in any cycle that neither loads nor shifts.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] data_q, data_d;
    logic         sout_q, sout_d;

    // sout_q always holds the bit currently on the wire; data_q holds the ones still to go
    always_comb begin
        data_d = data_q;
        sout_d = 1'b0;
        if (load) begin
            sout_d = din[0];
            data_d = {1'b0, din[W-1:1]};
        end else if (shift) begin
            sout_d = data_q[0];
            data_d = {1'b0, data_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sout_q <= 1'b0;
        end else begin
            data_q <= data_d;
            sout_q <= sout_d;
        end
    end

    assign sout = sout_q;

endmodule

// File: rtl/aes_spi_master.sv
// Host-side SPI master for the AES slave: shifts message then key out LSB-first,
// waits for the core to settle, then reads the 128-bit result back.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int NK     = 4,
    parameter int NR     = 10,
    parameter int SETTLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [127:0]        msg_in,
    input  logic [NK*32-1:0]    key_in,
    output logic                busy,
    output logic                done,
    output logic [127:0]        result,
    output logic                SIMO,
    output logic                CSS,
    output logic                mode,
    input  logic                SOMI
);

    localparam int KEY_W = key_bits(NK);
    localparam int L     = MSG_BITS + KEY_W;
    localparam int CNT_W = $clog2(L + 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_spi_master: NK=%0d unsupported, must be 4, 6 or 8", NK);
    end
    if (NR != NK + 6) begin : g_bad_nr
        $error("aes_spi_master: NR=%0d inconsistent with NK=%0d", NR, NK);
    end
    if (SETTLE < 1 || SETTLE > L) begin : g_bad_settle
        $error("aes_spi_master: SETTLE=%0d out of range", SETTLE);
    end

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MSG_BITS-1:0]    rx_q, rx_d;
    logic [MSG_BITS-1:0]    result_q, result_d;
    logic                   css_q, css_d;
    logic                   mode_q, mode_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   load, shift;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        result_d = result_q;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            LOAD: begin
                if (cnt_q == CNT_W'(L - 1)) begin
                    state_d = aes_spi_pkg::SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    shift = 1'b1;
                end
            end
            aes_spi_pkg::SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READ: begin
                // Slave lags one cycle, so cycle 0 carries no data
                if (cnt_q != '0) begin
                    rx_d = {SOMI, rx_q[MSG_BITS-1:1]};
                end
                if (cnt_q == CNT_W'(MSG_BITS)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = rx_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            load     = 1'b0;
            shift    = 1'b0;
            result_d = result_q;
        end
    end

    // Outputs are registered from the next state so they line up with state_q
    always_comb begin
        css_d  = !(state_d == LOAD || state_d == READ);
        mode_d = (state_d == READ) ? MODE_DECR : MODE_ENCR;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            result_q <= '0;
            css_q    <= 1'b1;
            mode_q   <= MODE_ENCR;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            result_q <= result_d;
            css_q    <= css_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    spi_shift_reg #(
        .W(L)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   ({key_in, msg_in}),
        .sout  (SIMO)
    );

    assign CSS    = css_q;
    assign mode   = mode_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench for aes_spi_master: NK=4 and NK=8 instances, each talking to a
// behavioural slave that captures SIMO and answers on SOMI one cycle late.
module tb_aes_spi_master;

    localparam logic [127:0] M1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] M3 = 128'hdeadbeef0123456789abcdefcafef00d;
    localparam logic [127:0] K3 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] M4 = 128'hffffffff00000000ffffffff00000000;
    localparam logic [127:0] M5 = 128'h13579bdf02468acefdb97531eca86420;
    localparam logic [127:0] K5 = 128'h5a5a5a5aa5a5a5a55a5a5a5aa5a5a5a5;
    localparam logic [127:0] M6 = 128'h0123456789abcdef0011223344556677;
    localparam logic [255:0] K6 = 256'h8899aabbccddeeff102132435465768798a9bacbdcedfe0f1e2d3c4b5a697887;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         start_a = 1'b0, abort_a = 1'b0, somi_a = 1'b0;
    logic [127:0] msg_a = '0, key_a = '0;
    logic         busy_a, done_a, simo_a, css_a, mode_a;
    logic [127:0] result_a;

    logic         start_b = 1'b0, abort_b = 1'b0, somi_b = 1'b0;
    logic [127:0] msg_b = '0;
    logic [255:0] key_b = '0;
    logic         busy_b, done_b, simo_b, css_b, mode_b;
    logic [127:0] result_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_spi_master #(.NK(4), .NR(10), .SETTLE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .msg_in(msg_a), .key_in(key_a), .busy(busy_a), .done(done_a),
        .result(result_a), .SIMO(simo_a), .CSS(css_a), .mode(mode_a), .SOMI(somi_a)
    );

    aes_spi_master #(.NK(8), .NR(14), .SETTLE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .msg_in(msg_b), .key_in(key_b), .busy(busy_b), .done(done_b),
        .result(result_b), .SIMO(simo_b), .CSS(css_b), .mode(mode_b), .SOMI(somi_b)
    );

    // Stand-in for the AES core: the FIPS-197 vector, otherwise msg ^ key
    function automatic logic [127:0] aes_stub(input logic [127:0] m, input logic [127:0] k);
        if (m == M1 && k == K1) return CT;
        return m ^ k;
    endfunction

    logic [255:0] cap_a = '0;
    logic [383:0] cap_b = '0;
    int           rk_a = 0, rk_b = 0;
    logic [127:0] resp_a, resp_b;
    int           dcount_a = 0, dcount_b = 0;

    always_comb resp_a = aes_stub(cap_a[127:0], cap_a[255:128]);
    always_comb resp_b = aes_stub(cap_b[127:0], cap_b[255:128] ^ cap_b[383:256]);

    // Slaves sample and drive on the falling edge, away from the DUT's edge
    always @(negedge clk) begin
        if (!css_a && !mode_a) cap_a <= {simo_a, cap_a[255:1]};
        if (!css_a && mode_a) begin
            somi_a <= (rk_a == 0) ? 1'b0 : resp_a[rk_a-1];
            rk_a   <= rk_a + 1;
        end else begin
            rk_a <= 0;
        end
        if (done_a) dcount_a <= dcount_a + 1;
    end

    always @(negedge clk) begin
        if (!css_b && !mode_b) cap_b <= {simo_b, cap_b[383:1]};
        if (!css_b && mode_b) begin
            somi_b <= (rk_b == 0) ? 1'b0 : resp_b[rk_b-1];
            rk_b   <= rk_b + 1;
        end else begin
            rk_b <= 0;
        end
        if (done_b) dcount_b <= dcount_b + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns just after the accept edge, i.e. in LOAD cycle 0
    task automatic go_a(input logic [127:0] m, input logic [127:0] k);
        msg_a   = m;
        key_a   = k;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // n counts edges from the accept edge (inclusive) to the one raising done
    task automatic wait_done_a(input int limit, output int n);
        n = 1;
        while (!done_a && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int css_low, css_high, simo_ones;
        logic simo0, css_read;
        logic [127:0] prev;
        int dprev;

        // 1. reset state and quiet idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_css", css_a, 1'b1);
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        check("reset_result", result_a, 128'h0);
        check("reset_simo_mode", {simo_a, mode_a}, 2'b00);
        check("reset_b", {css_b, busy_b, done_b}, 3'b100);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_hold", {css_a, busy_a, done_a}, 3'b100);

        // 2. NK=4 round trip with the FIPS-197 vector
        go_a(M1, K1);
        check("accept_busy", busy_a, 1'b1);
        wait_done_a(1000, n);
        $display("txn2: latency=%0d result=%h", n, result_a);
        check("rt_latency", n, 390);
        check("rt_result", result_a, CT);
        check("rt_slave_msg", cap_a[127:0], M1);
        check("rt_slave_key", cap_a[255:128], K1);
        @(posedge clk); #1;
        check("done_one_cycle", {done_a, busy_a, css_a}, 3'b001);
        check("done_hold_result", result_a, CT);

        // 3. SIMO/CSS trace with a single set message bit
        go_a(128'h1, 128'h0);
        css_low = 0; css_high = 0; simo_ones = 0; simo0 = simo_a;
        for (int i = 0; i < 260; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (simo_a) simo_ones++;
            if (i < 256 && !css_a) css_low++;
            if (i >= 256 && css_a) css_high++;
        end
        @(posedge clk); #1;
        css_read = css_a;
        $display("txn3: simo0=%0b ones=%0d css_low=%0d css_high=%0d", simo0, simo_ones, css_low, css_high);
        check("simo_cycle0", simo0, 1'b1);
        check("simo_ones", simo_ones, 1);
        check("css_low_load", css_low, 256);
        check("css_high_settle", css_high, 4);
        check("css_low_read", css_read, 1'b0);
        wait_done_a(1000, n);
        check("trace_result", result_a, 128'h1);

        // 4. start during LOAD is ignored
        @(posedge clk); #1;
        dprev = dcount_a;
        go_a(M3, K3);
        repeat (50) @(posedge clk);
        #1;
        msg_a   = M4;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done_a(1000, n);
        repeat (5) @(posedge clk);
        #1;
        $display("txn4: result=%h dones=%0d", result_a, dcount_a - dprev);
        check("busy_start_result", result_a, aes_stub(M3, K3));
        check("busy_start_one_done", dcount_a - dprev, 1);
        check("busy_start_slave_msg", cap_a[127:0], M3);

        // 5. abort at READ cycle 60
        prev  = result_a;
        dprev = dcount_a;
        go_a(M5, K5);
        repeat (320) @(posedge clk);
        #1;
        check("pre_abort_read", {css_a, mode_a}, 2'b01);
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        $display("txn5: css=%0b busy=%0b mode=%0b result=%h", css_a, busy_a, mode_a, result_a);
        check("abort_outputs", {css_a, busy_a, mode_a, simo_a, done_a}, 5'b10000);
        check("abort_result", result_a, prev);
        repeat (200) @(posedge clk);
        #1;
        check("abort_no_done", dcount_a - dprev, 0);
        check("abort_result_late", result_a, prev);

        // 6. reset during SETTLE, then an NK=8 transaction
        go_a(M1, K1);
        repeat (257) @(posedge clk);
        #1;
        check("settle_css", {css_a, busy_a}, 2'b11);
        rst_n = 1'b0;
        #1;
        $display("txn6: css=%0b busy=%0b result=%h after reset", css_a, busy_a, result_a);
        check("rst_outputs", {css_a, busy_a, done_a, simo_a, mode_a}, 5'b10000);
        check("rst_result", result_a, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        msg_b   = M6;
        key_b   = K6;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        $display("txn6b: latency=%0d result=%h", n, result_b);
        check("nk8_latency", n, 518);
        check("nk8_result", result_b, aes_stub(M6, K6[127:0] ^ K6[255:128]));
        check("nk8_slave_msg", cap_b[127:0], M6);
        check("nk8_slave_key", cap_b[383:128], K6);
        check("nk8_a_idle", {css_a, busy_a}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
